nios2_debug_cmd_bridge: RTL and testbench

Parametrised system-clock side of the Nios II debug slave: takes Update-DR events from the JTAG domain, synchronises them, captures the instruction and shift-register payload, and queues them as commands. It replaces the fixed 2-bit-IR / 38-bit "take_action" decoder with configurable widths, a command FIFO with valid/ready handshake, one-hot action decode and sticky overflow reporting. It sits between the virtual JTAG TCK-side logic and the OCI break, ocimem and trace-control consumers.

---
 rtl/nios2_debug_pkg.sv | 28 ++
 rtl/nios2_debug_cmd_fifo.sv | 69 ++++++
 rtl/nios2_debug_cmd_bridge.sv | 95 +++++++++
 tb/tb_nios2_debug_cmd_bridge.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_debug_pkg.sv
// Shared constants, sizing rules and command type for the Nios II debug
// command bridge.
package nios2_debug_pkg;

   localparam int unsigned DEF_DATA_W      = 38;
   localparam int unsigned DEF_IR_W        = 2;
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_FIFO_DEPTH  = 4;

   function automatic int unsigned num_act(input int unsigned ir_w);
      return 1 << ir_w;
   endfunction

   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // One bit of the one-hot action decode: set when the instruction selects action k.
   function automatic logic act_hit(input int unsigned code, input int unsigned k);
      return code == k;
   endfunction

   typedef struct packed {
      logic [DEF_IR_W-1:0]   ir;
      logic [DEF_DATA_W-1:0] data;
   } cmd_t;

endpackage

// File: rtl/nios2_debug_cmd_fifo.sv
// Synchronous command FIFO with a registered head; a push into a full queue
// is accepted only when a pop happens in the same cycle.
module nios2_debug_cmd_fifo #(
   parameter  int unsigned W     = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned LW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic          valid_o,
   output logic [W-1:0]  head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] level_d;
   logic          valid_q, full_q, empty_q;
   logic [W-1:0]  head_q;
   logic          do_push, do_pop;

   always_comb begin
      do_pop  = pop_i && valid_q;
      do_push = push_i && (!full_q || do_pop);
      wr_d    = wr_q + LW'(do_push);
      rd_d    = rd_q + LW'(do_pop);
      level_d = wr_d - rd_d;
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

   // Head is loaded from the next read slot; a write landing in that slot
   // this cycle has not reached memory yet, so bypass it.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         valid_q <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         head_q  <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         valid_q <= level_d != '0;
         empty_q <= level_d == '0;
         full_q  <= level_d == LW'(DEPTH);
         if (level_d != '0) begin
            if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) head_q <= wdata_i;
            else                                          head_q <= mem_q[rd_d[AW-1:0]];
         end
      end
   end

   assign valid_o = valid_q;
   assign head_o  = head_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign level_o = wr_q - rd_q;

endmodule

// File: rtl/nios2_debug_cmd_bridge.sv
// System-clock side of the Nios II debug slave: synchronises Update-DR toggles
// and queues {ir, sr} commands with valid/ready, one-hot decode and overflow.
module nios2_debug_cmd_bridge
   import nios2_debug_pkg::*;
#(
   parameter  int unsigned DATA_W      = DEF_DATA_W,
   parameter  int unsigned IR_W        = DEF_IR_W,
   parameter  int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter  int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
   localparam int unsigned NUM_ACT     = num_act(IR_W),
   localparam int unsigned LVL_W       = level_w(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              upd_tgl,
   input  logic [IR_W-1:0]   ir_in,
   input  logic [DATA_W-1:0] sr_in,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [IR_W-1:0]   cmd_ir,
   output logic [DATA_W-1:0] cmd_data,
   output logic [NUM_ACT-1:0] cmd_action,
   output logic [LVL_W-1:0]  fifo_level,
   output logic              overflow,
   input  logic              clr_overflow
);

   localparam int unsigned   ARM_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);
   localparam int unsigned   CMD_W    = IR_W + DATA_W;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   tgl_prev_q;
   logic [ARM_W-1:0]       arm_q;
   logic                   push_q;
   logic [CMD_W-1:0]       push_cmd_q;
   logic                   overflow_q;
   logic                   edge_ok, pop, drop;
   logic                   fifo_full, fifo_empty;
   logic [CMD_W-1:0]       head;

   always_comb begin
      edge_ok = (sync_q[SYNC_STAGES-1] ^ tgl_prev_q) && (arm_q == '0);
      pop     = cmd_ready && !fifo_empty;
      drop    = push_q && fifo_full && !pop;
   end

   // tgl_prev tracks the synchroniser even while disarmed, so a toggle level
   // held across reset is absorbed instead of becoming a command.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= '0;
         tgl_prev_q <= 1'b0;
         arm_q      <= ARM_INIT;
         push_q     <= 1'b0;
         push_cmd_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], upd_tgl};
         tgl_prev_q <= sync_q[SYNC_STAGES-1];
         if (arm_q != '0) arm_q <= arm_q - ARM_W'(1);
         push_q     <= edge_ok;
         if (edge_ok) push_cmd_q <= {ir_in, sr_in};
         if (drop)              overflow_q <= 1'b1;
         else if (clr_overflow) overflow_q <= 1'b0;
      end
   end

   nios2_debug_cmd_fifo #(
      .W     (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_q),
      .wdata_i (push_cmd_q),
      .pop_i   (pop),
      .valid_o (cmd_valid),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign cmd_ir   = head[DATA_W +: IR_W];
   assign cmd_data = head[DATA_W-1:0];
   assign overflow = overflow_q;

   always_comb begin
      cmd_action = '0;
      for (int unsigned k = 0; k < NUM_ACT; k++)
         cmd_action[k] = cmd_valid && act_hit(int'(cmd_ir), k);
   end

endmodule

// File: tb/tb_nios2_debug_cmd_bridge.sv
// Self-checking bench for nios2_debug_cmd_bridge: directed table and sequences
// plus randomized traffic against a queue-based reference model.
module tb_nios2_debug_cmd_bridge;
   import nios2_debug_pkg::*;

   localparam int unsigned DW = 38, IW = 2, SS = 2, FD = 4, NA = 4, LW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1, upd_tgl = 1'b1, cmd_ready = 1'b0, clr_overflow = 1'b0;
   logic [IW-1:0] ir_in = '0;
   logic [DW-1:0] sr_in = '0;
   logic          cmd_valid, overflow;
   logic [IW-1:0] cmd_ir;
   logic [DW-1:0] cmd_data;
   logic [NA-1:0] cmd_action;
   logic [LW-1:0] fifo_level;

   nios2_debug_cmd_bridge #(
      .DATA_W(DW), .IR_W(IW), .SYNC_STAGES(SS), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset(reset), .upd_tgl(upd_tgl), .ir_in(ir_in), .sr_in(sr_in),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
      .cmd_action(cmd_action), .fifo_level(fifo_level), .overflow(overflow),
      .clr_overflow(clr_overflow)
   );

   int checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: a toggle first seen at edge t0 (level differs from the
   // last seen level, 0 after reset) becomes a push at edge t0+SS+1, unless
   // t0 is within two edges of the last reset edge.
   typedef struct { int t; cmd_t c; } pend_t;
   cmd_t  mq[$];
   pend_t pq[$];
   bit    movf = 1'b0, seen = 1'b0;
   int    cyc = 0, rlast = 0;

   task automatic model_edge();
      bit pop, push, set;
      int sz;
      pend_t p;
      if (reset) begin
         mq.delete(); pq.delete();
         movf = 1'b0; seen = 1'b0; rlast = cyc;
      end else begin
         sz   = mq.size();
         pop  = (sz != 0) && cmd_ready;
         push = (pq.size() != 0) && (pq[0].t == cyc);
         set  = 1'b0;
         if (pop) void'(mq.pop_front());
         if (push) begin
            p = pq.pop_front();
            if (sz == FD && !pop) set = 1'b1;
            else mq.push_back(p.c);
         end
         if (set) movf = 1'b1;
         else if (clr_overflow) movf = 1'b0;
         if (upd_tgl != seen) begin
            seen = upd_tgl;
            if (cyc >= rlast + 2) begin
               p.t = cyc + SS + 1; p.c.ir = ir_in; p.c.data = sr_in;
               pq.push_back(p);
            end
         end
      end
      cyc++;
   endtask

   task automatic model_check();
      logic [63:0] oh;
      chk("valid", cmd_valid, mq.size() != 0);
      chk("level", fifo_level, mq.size());
      chk("overflow", overflow, movf);
      if (mq.size() != 0) begin
         oh = 64'd1 << mq[0].ir;
         chk("ir", cmd_ir, mq[0].ir);
         chk("data", cmd_data, mq[0].data);
         chk("action", cmd_action, oh);
      end else begin
         chk("action_empty", cmd_action, 0);
      end
   endtask

   task automatic step(input bit r, input bit flip, input logic [IW-1:0] ir,
                       input logic [DW-1:0] sr, input bit rdy, input bit clr);
      @(negedge clk);
      reset = r;
      if (flip) begin upd_tgl = ~upd_tgl; ir_in = ir; sr_in = sr; end
      cmd_ready = rdy;
      clr_overflow = clr;
      @(posedge clk);
      model_edge();
      #1;
      model_check();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, rdy, 1'b0);
   endtask

   // Four toggles spaced four cycles apart, consumer stalled.
   task automatic fill4();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, IW'(i), {$urandom, 6'(i)}, 1'b0, 1'b0);
         idle(3, 1'b0);
      end
   endtask

   typedef struct {
      bit            flip;
      logic [IW-1:0] ir;
      logic [DW-1:0] sr;
      bit            rdy;
      bit            ev;
      logic [LW-1:0] el;
      bit            eo;
      logic [NA-1:0] ea;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{1'b1, 2'd2, 38'h2A_5555_AAAA, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000};
      tbl[1] = '{1'b0, 2'd0, 38'h0,            1'b0, 1'b0, 3'd0, 1'b0, 4'b0000};
      tbl[2] = '{1'b0, 2'd0, 38'h0,            1'b0, 1'b0, 3'd0, 1'b0, 4'b0000};
      tbl[3] = '{1'b0, 2'd0, 38'h0,            1'b0, 1'b1, 3'd1, 1'b0, 4'b0100};
      tbl[4] = '{1'b0, 2'd0, 38'h0,            1'b0, 1'b1, 3'd1, 1'b0, 4'b0100};
      tbl[5] = '{1'b0, 2'd0, 38'h0,            1'b1, 1'b0, 3'd0, 1'b0, 4'b0000};

      // Reset with the toggle held high, then 20 quiet cycles.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("rst_ir", cmd_ir, 0);
      chk("rst_data", cmd_data, 0);
      chk("rst_action", cmd_action, 0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
         chk("arm_valid", cmd_valid, 0);
         chk("arm_ovf", overflow, 0);
         chk("arm_level", fifo_level, 0);
      end

      // Single toggle: latency, decode and hold-until-ready.
      foreach (tbl[i]) begin
         step(1'b0, tbl[i].flip, tbl[i].ir, tbl[i].sr, tbl[i].rdy, 1'b0);
         chk("tbl_valid", cmd_valid, tbl[i].ev);
         chk("tbl_level", fifo_level, tbl[i].el);
         chk("tbl_ovf", overflow, tbl[i].eo);
         chk("tbl_action", cmd_action, tbl[i].ea);
         if (tbl[i].ev) begin
            chk("tbl_ir", cmd_ir, 2);
            chk("tbl_data", cmd_data, 38'h2A_5555_AAAA);
         end
      end

      // Five toggles while stalled: fifth dropped, overflow sticky until cleared.
      fill4();
      step(1'b0, 1'b1, 2'd1, 38'h15_0F0F_F0F0, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("ovf_level", fifo_level, 4);
      chk("ovf_set", overflow, 1);
      idle(4, 1'b1);
      chk("ovf_drained", fifo_level, 0);
      chk("ovf_held", overflow, 1);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      chk("ovf_clr", overflow, 0);

      // Full queue, pop in the same cycle as the push: accepted, no overflow.
      fill4();
      step(1'b0, 1'b1, 2'd3, 38'h3F_1234_5678, 1'b0, 1'b0);
      idle(2, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      chk("pp_level", fifo_level, 4);
      chk("pp_ovf", overflow, 0);
      idle(5, 1'b1);

      // Drop and clear in the same cycle: set wins.
      fill4();
      step(1'b0, 1'b1, 2'd0, 38'h01_0000_0001, 1'b0, 1'b0);
      idle(2, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      chk("setclr_ovf", overflow, 1);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      chk("setclr_after", overflow, 0);
      idle(5, 1'b1);

      // Reset with three queued entries; toggle in the arm window is ignored.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, IW'(i + 1), {$urandom, 6'(i)}, 1'b0, 1'b0);
         idle(3, 1'b0);
      end
      chk("pre_rst_level", fifo_level, 3);
      step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("flush_valid", cmd_valid, 0);
      chk("flush_level", fifo_level, 0);
      step(1'b0, 1'b1, 2'd1, 38'h11_1111_1111, 1'b0, 1'b0);
      idle(6, 1'b0);
      chk("window_ignored", cmd_valid, 0);
      step(1'b0, 1'b1, 2'd3, 38'h22_2222_2222, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("post_arm_valid", cmd_valid, 1);
      chk("post_arm_data", cmd_data, 38'h22_2222_2222);
      idle(3, 1'b1);

      // Randomized traffic against the model.
      begin
         int gap = 0;
         int rdy_pct = 50;
         for (int i = 0; i < 3000; i++) begin
            bit r, f, rd, cl;
            if (i % 200 == 0) rdy_pct = $urandom_range(5, 95);
            r  = ($urandom_range(0, 199) == 0);
            f  = (gap >= int'(SS) + 2) && ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 99) < rdy_pct);
            cl = ($urandom_range(0, 19) == 0);
            gap = f ? 0 : gap + 1;
            step(r, f, IW'($urandom), {$urandom, 6'($urandom)}, rd, cl);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
